vga_scan_out: RTL and testbench
===============================

VGA_SCAN_OUT -- requirements
Module: vga_scan_out

Interface
REQ-001 Parameters (name, default, meaning): H_DISPLAY 256 visible pixels per line; H_FRONT 7 front porch; H_SYNC 23 hsync width; H_BACK 23 back porch; V_DISPLAY 240 visible lines; V_BOTTOM 14 bottom porch; V_SYNC 3 vsync lines; V_TOP 5 top porch.
REQ-002 clk  input  1  system clock, the single clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 fb_addr  output  16  framebuffer read address, {y[7:0], x[7:0]}.
REQ-005 fb_rd  output  1  framebuffer read strobe, one clk per visible pixel.
REQ-006 fb_data  input  3  framebuffer pixel, valid exactly 1 clk after the fb_rd cycle.
REQ-007 hsync  output  1  horizontal sync, active low.
REQ-008 vsync  output  1  vertical sync, active low.
REQ-009 rgb  output  3  pixel colour, forced 0 outside the visible area.
REQ-010 frame_start  output  1  one-clk pulse at the first pixel (0,0) of each frame.
REQ-011 pattern_sel  input  1  test-pattern select (see Configuration).

Function
REQ-012 pix_en toggles every clk; h/v counters and outputs advance only on cycles with pix_en=1, giving one pixel per 2 clk.
REQ-013 h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params = 309), then wraps to 0 and increments v_cnt.
REQ-014 v_cnt counts 0..V_TOTAL-1 (V_TOTAL = 262), then wraps to 0; h and v wrap in the same pix_en cycle at (308,261).
REQ-015 visible = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
REQ-016 fb_rd = visible && pix_en; fb_addr = {v_cnt[7:0], h_cnt[7:0]} on that cycle; fb_addr holds its last value otherwise.
REQ-017 Raw hsync low for h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [263,285].
REQ-018 Raw vsync low for v_cnt in [V_DISPLAY+V_BOTTOM, V_DISPLAY+V_BOTTOM+V_SYNC-1] = [254,256].
REQ-019 hsync, vsync, visible and frame_start are delayed through a 2-stage pipeline, so outputs align with fb_data; total latency from counter state to output pins is exactly 2 clk.
REQ-020 rgb is registered: fb_data when the delayed visible is 1, else 3'b000.
REQ-021 Sync outputs are held high during the visible area, so a monitor sampling every second clk sees hsync=vsync=1 only while rgb is meaningful or in porches.
REQ-022 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-023 While reset=0: h_cnt=0, v_cnt=0, pix_en=0, fb_rd=0, fb_addr=0, rgb=0, hsync=1, vsync=1, frame_start=0, pipeline cleared.
REQ-024 Reset asserted mid-line or mid-frame takes effect immediately; the first pixel after release is (0,0) with a frame_start pulse.
REQ-025 The first pix_en=1 cycle is the second rising clk edge after reset release.

Configuration
REQ-026 Macro VGA_TEST_PATTERN_EN: when defined and pattern_sel=1, rgb in the visible area = h_cnt[7:5] of the delayed pixel (8 vertical colour bars of 32 px), and fb_rd stays 0.
REQ-027 Without VGA_TEST_PATTERN_EN, pattern_sel is ignored and rgb always comes from fb_data; port list is unchanged.

Structure
REQ-028 Package vga_scan_pkg holds the timing defaults, derived H_TOTAL/V_TOTAL, the hsync/vsync start and end constants and the fb address width.
REQ-029 Sub-module vga_timing_cnt (h/v counters, visible, raw syncs) is instantiated once; vga_scan_out adds pix_en, fetch, pipeline and colour muxing.

Verification
REQ-030 Release reset, fb_data=3'b101 constant -> frame_start at clk 3 after release; rgb=5 for 256 pixels (512 clk), then 0.
REQ-031 Run one line -> hsync low for exactly 23 pixels (46 clk), starting 263 pixels after line start; line period 618 clk.
REQ-032 Run one frame -> vsync low for 3 lines (3*618 clk) beginning at line 254; frame period 262*618 = 161916 clk; frame_start period identical.
REQ-033 Framebuffer model returning fb_addr[2:0] -> rgb on pixel x equals x[2:0] with 2-clk alignment, no off-by-one at x=0 or x=255.
REQ-034 Assert reset at line 100, pixel 50 -> all outputs take reset values within the same clk; after release, frame restarts at (0,0).
REQ-035 With VGA_TEST_PATTERN_EN and pattern_sel=1 -> pixels 0..31 rgb=0, 32..63 rgb=1, ..., 224..255 rgb=7; fb_rd never asserted.

Source files
------------

// File: rtl/vga_scan_pkg.sv
// Shared timing defaults, derived totals and sync window helpers for the VGA scan-out block.
package vga_scan_pkg;

    localparam int unsigned H_DISPLAY_DEF = 256;
    localparam int unsigned H_FRONT_DEF   = 7;
    localparam int unsigned H_SYNC_DEF    = 23;
    localparam int unsigned H_BACK_DEF    = 23;
    localparam int unsigned V_DISPLAY_DEF = 240;
    localparam int unsigned V_BOTTOM_DEF  = 14;
    localparam int unsigned V_SYNC_DEF    = 3;
    localparam int unsigned V_TOP_DEF     = 5;

    localparam int unsigned H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF = V_DISPLAY_DEF + V_BOTTOM_DEF + V_SYNC_DEF + V_TOP_DEF;

    localparam int unsigned HS_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int unsigned VS_START_DEF = V_DISPLAY_DEF + V_BOTTOM_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    localparam int unsigned FB_ADDR_W = 16;
    localparam int unsigned COLOR_W   = 3;
    localparam int unsigned CNT_W     = 10;

    function automatic int unsigned sync_start(input int unsigned disp, input int unsigned porch);
        return disp + porch;
    endfunction

    function automatic int unsigned sync_end(input int unsigned disp, input int unsigned porch,
                                             input int unsigned width);
        return disp + porch + width - 1;
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical raster counters with visible-area and raw (active-low) sync decode.
module vga_timing_cnt
    import vga_scan_pkg::*;
#(
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_BOTTOM  = V_BOTTOM_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_TOP     = V_TOP_DEF
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             visible,
    output logic             hsync_raw,
    output logic             vsync_raw
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_DISPLAY, H_FRONT));
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_DISPLAY, V_BOTTOM));
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_end(V_DISPLAY, V_BOTTOM, V_SYNC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync_raw = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
        vsync_raw = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
    end

endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: pixel enable, framebuffer fetch, 2-clk sync/colour pipeline.
// Optional macro VGA_TEST_PATTERN_EN adds colour-bar output selected by pattern_sel.
module vga_scan_out
    import vga_scan_pkg::*;
#(
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_BOTTOM  = V_BOTTOM_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_TOP     = V_TOP_DEF
)
(
    input  logic                 clk,
    input  logic                 reset,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic                 fb_rd,
    input  logic [COLOR_W-1:0]   fb_data,
    output logic                 hsync,
    output logic                 vsync,
    output logic [COLOR_W-1:0]   rgb,
    output logic                 frame_start,
    input  logic                 pattern_sel
);

    logic             pix_en;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             visible;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             fetch_go;
    logic [COLOR_W-1:0] pix_colour;

    logic s1_vis;
    logic s1_hs;
    logic s1_vs;
    logic s1_fs;

    vga_timing_cnt #(
        .H_DISPLAY (H_DISPLAY),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_DISPLAY (V_DISPLAY),
        .V_BOTTOM  (V_BOTTOM),
        .V_SYNC    (V_SYNC),
        .V_TOP     (V_TOP)
    ) u_timing_cnt (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .visible   (visible),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    // Counters are stable across the pix_en=0/1 pair, so registering the fetch on the
    // pix_en=0 edge makes fb_rd exactly equal to visible && pix_en without a comb output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_rd   <= 1'b0;
            fb_addr <= '0;
        end else if (!pix_en) begin
            fb_rd <= fetch_go;
            if (fetch_go) begin
                fb_addr <= {v_cnt[7:0], h_cnt[7:0]};
            end
        end else begin
            fb_rd <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vis <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_fs  <= 1'b0;
        end else if (pix_en) begin
            s1_vis <= visible;
            s1_hs  <= hsync_raw;
            s1_vs  <= vsync_raw;
            s1_fs  <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic         fetch_pat;
    logic         s1_pat;
    logic [2:0]   s1_bar;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pat <= 1'b0;
            s1_pat    <= 1'b0;
            s1_bar    <= '0;
        end else if (!pix_en) begin
            fetch_pat <= pattern_sel;
        end else begin
            s1_pat <= fetch_pat;
            s1_bar <= h_cnt[7:5];
        end
    end

    always_comb begin
        fetch_go   = visible && !pattern_sel;
        pix_colour = s1_pat ? s1_bar : fb_data;
    end
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;

    always_comb begin
        fetch_go   = visible;
        pix_colour = fb_data;
    end
`endif

    // Outputs update on pix_en=0 edges, the one clk where fb_data for the pixel is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= !pix_en && s1_fs;
            if (!pix_en) begin
                hsync <= s1_hs;
                vsync <= s1_vs;
                rgb   <= s1_vis ? pix_colour : '0;
            end
        end
    end

    logic unused_cnt_hi;
    assign unused_cnt_hi = ^{h_cnt[CNT_W-1:8], v_cnt[CNT_W-1:8]};

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out with a shortened vertical raster (12 lines per frame).
module tb_vga_scan_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] fb_addr;
    logic        fb_rd;
    logic [2:0]  fb_data;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic        frame_start;
    logic        pattern_sel;

    int          fb_mode;
    int unsigned ec;
    int          n_tests;
    int          n_fail;

    int unsigned rgb5_cnt, rgb_first, rgb_last, hs_low_cnt, hs_first, rd_cnt, fs_cnt, vs_low_cnt;

    vga_scan_out #(
        .H_DISPLAY (256),
        .H_FRONT   (7),
        .H_SYNC    (23),
        .H_BACK    (23),
        .V_DISPLAY (6),
        .V_BOTTOM  (2),
        .V_SYNC    (2),
        .V_TOP     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fb_addr     (fb_addr),
        .fb_rd       (fb_rd),
        .fb_data     (fb_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start),
        .pattern_sel (pattern_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] fb_value(input logic [15:0] a, input int mode);
        return (mode == 1) ? a[2:0] : 3'b101;
    endfunction

    // One-cycle read latency; outside that cycle the bus carries the complement.
    always @(posedge clk)
        fb_data <= fb_rd ? fb_value(fb_addr, fb_mode) : ~fb_value(fb_addr, fb_mode);

    task automatic clear_stats();
        rgb5_cnt = 0; rgb_first = 0; rgb_last = 0; hs_low_cnt = 0;
        hs_first = 0; rd_cnt = 0; fs_cnt = 0; vs_low_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ec++;
        if (rgb == 3'd5) rgb5_cnt++;
        if (rgb != 3'd0) begin
            if (rgb_first == 0) rgb_first = ec;
            rgb_last = ec;
        end
        if (!hsync) begin
            if (hs_first == 0) hs_first = ec;
            hs_low_cnt++;
        end
        if (!vsync) vs_low_cnt++;
        if (fb_rd) rd_cnt++;
        if (frame_start) fs_cnt++;
    endtask

    task automatic run_to(input int unsigned n);
        while (ec < n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_fb_rd"},   32'(fb_rd), 0);
        check({tag, "_fb_addr"}, 32'(fb_addr), 0);
        check({tag, "_rgb"},     32'(rgb), 0);
        check({tag, "_hsync"},   32'(hsync), 1);
        check({tag, "_vsync"},   32'(vsync), 1);
        check({tag, "_fs"},      32'(frame_start), 0);
    endtask

    int xs_a[5] = '{0, 1, 7, 8, 100};
    int xs_b[2] = '{254, 255};
    int xs_p[7] = '{0, 31, 32, 63, 100, 224, 255};

    initial begin
        n_tests = 0; n_fail = 0; ec = 0; fb_mode = 0;
        pattern_sel = 1'b0;
        reset = 1'b0;
        clear_stats();

        repeat (3) tick();
        check_reset_state("por");

        reset = 1'b1;
        ec = 0;
        clear_stats();

        tick();
        check("e1_fb_rd", 32'(fb_rd), 1);
        check("e1_fb_addr", 32'(fb_addr), 0);
        check("e1_fs", 32'(frame_start), 0);
        tick();
        check("e2_fs", 32'(frame_start), 0);
        check("e2_fb_rd", 32'(fb_rd), 0);
        tick();
        check("e3_fs", 32'(frame_start), 1);
        check("e3_rgb", 32'(rgb), 5);
        tick();
        check("e4_fs", 32'(frame_start), 0);

        run_to(618);
        check("l0_rgb5_cnt", rgb5_cnt, 512);
        check("l0_rgb_first", rgb_first, 3);
        check("l0_rgb_last", rgb_last, 514);
        check("l0_hs_low_cnt", hs_low_cnt, 46);
        check("l0_hs_first", hs_first, 529);
        check("l0_rd_cnt", rd_cnt, 256);
        check("l0_fs_cnt", fs_cnt, 1);
        check("l0_vs_low_cnt", vs_low_cnt, 0);

        run_to(620);
        check("l1_pre_rgb", 32'(rgb), 0);
        tick();
        check("l1_first_rgb", 32'(rgb), 5);

        run_to(1146);
        fb_mode = 1;
        check("l1_hs_before", 32'(hsync), 1);
        tick();
        check("l1_hs_start", 32'(hsync), 0);

        run_to(1237);
        check("l2_x0_fb_rd", 32'(fb_rd), 1);
        check("l2_x0_fb_addr", 32'(fb_addr), 32'h0200);
        run_to(1238);
        check("l2_pre_rgb", 32'(rgb), 0);
        for (int i = 0; i < 5; i++) begin
            run_to(1239 + 2 * xs_a[i]);
            check($sformatf("l2_x%0d_rgb_a", xs_a[i]), 32'(rgb), xs_a[i] & 7);
            tick();
            check($sformatf("l2_x%0d_rgb_b", xs_a[i]), 32'(rgb), xs_a[i] & 7);
        end
        run_to(1747);
        check("l2_x255_fb_addr", 32'(fb_addr), 32'h02FF);
        for (int i = 0; i < 2; i++) begin
            run_to(1239 + 2 * xs_b[i]);
            check($sformatf("l2_x%0d_rgb_a", xs_b[i]), 32'(rgb), xs_b[i] & 7);
            tick();
            check($sformatf("l2_x%0d_rgb_b", xs_b[i]), 32'(rgb), xs_b[i] & 7);
        end
        run_to(1751);
        check("l2_x256_rgb", 32'(rgb), 0);

        run_to(3709);
        check("l6_fb_rd", 32'(fb_rd), 0);
        check("l6_fb_addr_hold", 32'(fb_addr), 32'h05FF);
        run_to(3711);
        check("l6_rgb", 32'(rgb), 0);
        clear_stats();

        run_to(4946);
        check("vs_before", 32'(vsync), 1);
        tick();
        check("vs_start", 32'(vsync), 0);
        run_to(6183);
        check("vs_end", 32'(vsync), 1);
        check("vs_low_cnt", vs_low_cnt, 1236);

        run_to(7418);
        check("f1_fs_none", fs_cnt, 0);
        tick();
        check("f1_fs", 32'(frame_start), 1);
        tick();
        check("f1_fs_end", 32'(frame_start), 0);

        run_to(9371);
        check("pre_rst_fb_addr", 32'(fb_addr), 32'h0332);
        check("pre_rst_rgb", 32'(rgb), 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("async_rst");

        pattern_sel = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        ec = 0;
        clear_stats();

        tick();
        check("rs_e1_fs", 32'(frame_start), 0);
`ifdef VGA_TEST_PATTERN_EN
        check("rs_e1_fb_rd", 32'(fb_rd), 0);
`else
        check("rs_e1_fb_rd", 32'(fb_rd), 1);
`endif
        run_to(3);
        check("rs_e3_fs", 32'(frame_start), 1);
        for (int i = 0; i < 7; i++) begin
            run_to(3 + 2 * xs_p[i]);
`ifdef VGA_TEST_PATTERN_EN
            check($sformatf("pat_x%0d_rgb", xs_p[i]), 32'(rgb), xs_p[i] >> 5);
`else
            check($sformatf("pat_x%0d_rgb", xs_p[i]), 32'(rgb), xs_p[i] & 7);
`endif
        end
        run_to(515);
        check("pat_x256_rgb", 32'(rgb), 0);
        run_to(618);
`ifdef VGA_TEST_PATTERN_EN
        check("pat_rd_cnt", rd_cnt, 0);
`else
        check("pat_rd_cnt", rd_cnt, 256);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
